// File: rtl/prio_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_enc_pkg                                                         |
// | Shared seven-segment constants and hex font for prio_enc_disp.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package prio_enc_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low g..a patterns for hex digits 0-F
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return SEG_FONT[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | req_debounce                                                         |
// | 2-FF synchroniser followed by a whole-vector stability debouncer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module req_debounce
    import prio_enc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] req_db
);

    localparam int            CW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] c_cnt_max = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_req_db;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= req;
            r_sync2 <= r_sync1;
        end
    end

    // Counter saturates at its max; req_db reloads the same value while stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_req_db <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_req_db <= r_cand;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign req_db = r_req_db;

endmodule
`default_nettype wire

// File: rtl/prio_enc_disp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_enc_disp                                                        |
// | Debounced priority encoder with change counter and hex display.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prio_enc_disp
    import prio_enc_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int DEB_CYCLES = 1000,
    localparam int IW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             en,
    input  logic             lowfirst,
    input  logic             hold,
    output logic [IW-1:0]    idx,
    output logic             valid,
    output logic [7:0]       chg_cnt,
    output logic [7:0]       seg_idx_lo,
    output logic [7:0]       seg_idx_hi,
    output logic [7:0]       seg_cnt_lo,
    output logic [7:0]       seg_cnt_hi
);

    logic [WIDTH-1:0] w_req_db;
    logic [IW-1:0]    w_hi_idx;
    logic [IW-1:0]    w_lo_idx;
    logic [7:0]       w_idx8;

    logic [IW-1:0]    r_idx;
    logic             r_valid;
    logic             r_enc_en;
    logic [IW:0]      r_prev_pair;
    logic [7:0]       r_chg_cnt;
    logic [7:0]       r_seg_idx_lo;
    logic [7:0]       r_seg_idx_hi;
    logic [7:0]       r_seg_cnt_lo;
    logic [7:0]       r_seg_cnt_hi;

    req_debounce #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_req_debounce (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .req_db (w_req_db)
    );

    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_req_db[i]) w_hi_idx = IW'(i);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_req_db[i]) w_lo_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_enc_en <= 1'b0;
        end else if (!hold) begin
            r_enc_en <= en;
            r_valid  <= en & (|w_req_db);
            r_idx    <= !en ? '0 : (lowfirst ? w_lo_idx : w_hi_idx);
        end
    end

    // Compares against the pair seen last unheld cycle, so a change is counted one edge late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_pair <= '0;
            r_chg_cnt   <= '0;
        end else if (!hold) begin
            r_prev_pair <= {r_valid, r_idx};
            if ({r_valid, r_idx} != r_prev_pair) r_chg_cnt <= r_chg_cnt + 8'd1;
        end
    end

    assign w_idx8 = 8'(r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_idx_lo <= SEG_BLANK;
            r_seg_idx_hi <= SEG_BLANK;
            r_seg_cnt_lo <= SEG_BLANK;
            r_seg_cnt_hi <= SEG_BLANK;
        end else begin
            r_seg_idx_lo <= r_enc_en ? {~r_valid, hex2seg(w_idx8[3:0])} : SEG_BLANK;
            r_seg_idx_hi <= (IW > 4 && r_enc_en) ? {1'b1, hex2seg(w_idx8[7:4])} : SEG_BLANK;
            r_seg_cnt_lo <= {1'b1, hex2seg(r_chg_cnt[3:0])};
            r_seg_cnt_hi <= {1'b1, hex2seg(r_chg_cnt[7:4])};
        end
    end

    assign idx        = r_idx;
    assign valid      = r_valid;
    assign chg_cnt    = r_chg_cnt;
    assign seg_idx_lo = r_seg_idx_lo;
    assign seg_idx_hi = r_seg_idx_hi;
    assign seg_cnt_lo = r_seg_cnt_lo;
    assign seg_cnt_hi = r_seg_cnt_hi;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_disp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prio_enc_disp                                                     |
// | Directed and random stimulus against a history-window model.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_prio_enc_disp;

    localparam int DEB = 4;
    localparam int HL  = DEB + 3;

    // Active-high g..a hex font
    localparam logic [6:0] SEG_ON [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic       en = 1'b1;
    logic       lowfirst = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] chg_cnt, seg_idx_lo, seg_idx_hi, seg_cnt_lo, seg_cnt_hi;

    int n_checks = 0;
    int n_errors = 0;

    prio_enc_disp #(.WIDTH(8), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .req(req), .en(en), .lowfirst(lowfirst), .hold(hold),
        .idx(idx), .valid(valid), .chg_cnt(chg_cnt),
        .seg_idx_lo(seg_idx_lo), .seg_idx_hi(seg_idx_hi),
        .seg_cnt_lo(seg_cnt_lo), .seg_cnt_hi(seg_cnt_hi)
    );

    always #5 clk = ~clk;

    // Reference model: req_db is the oldest sample of a DEB+1 long window of
    // req history (ending two edges back) whenever that whole window agrees.
    logic [7:0] m_hist [HL];
    logic [7:0] m_db, m_cnt;
    logic       m_valid, m_enc_en;
    logic [2:0] m_idx;
    logic [3:0] m_last;
    logic [7:0] m_seg_il, m_seg_ih, m_seg_cl, m_seg_ch;

    function automatic int flog2(input int v);
        int p = 0;
        while (v > 1) begin
            v = v >> 1;
            p++;
        end
        return p;
    endfunction

    function automatic bit win_stable();
        for (int j = 2; j <= DEB + 1; j++) if (m_hist[j] != m_hist[1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] nib);
        return {1'b1, ~SEG_ON[nib]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HL; i++) m_hist[i] <= 8'h00;
            m_db <= 8'h00; m_cnt <= 8'h00; m_valid <= 1'b0; m_enc_en <= 1'b0;
            m_idx <= 3'd0; m_last <= 4'h0;
            m_seg_il <= 8'hFF; m_seg_ih <= 8'hFF; m_seg_cl <= 8'hFF; m_seg_ch <= 8'hFF;
        end else begin
            for (int i = 0; i < HL - 1; i++) m_hist[i] <= m_hist[i + 1];
            m_hist[HL - 1] <= req;
            if (win_stable()) m_db <= m_hist[1];
            if (!hold) begin
                m_enc_en <= en;
                m_valid  <= en && (m_db != 8'h00);
                if (!en || m_db == 8'h00) m_idx <= 3'd0;
                else if (lowfirst)        m_idx <= 3'(flog2(int'(m_db) & -int'(m_db)));
                else                      m_idx <= 3'(flog2(int'(m_db)));
                if ({m_valid, m_idx} != m_last) begin
                    m_cnt  <= m_cnt + 8'd1;
                    m_last <= {m_valid, m_idx};
                end
            end
            m_seg_il <= m_enc_en ? {~m_valid, ~SEG_ON[{1'b0, m_idx}]} : 8'hFF;
            m_seg_ih <= 8'hFF;
            m_seg_cl <= digit(m_cnt[3:0]);
            m_seg_ch <= digit(m_cnt[7:4]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("idx",        32'(idx),        32'(m_idx));
        check_eq("valid",      32'(valid),      32'(m_valid));
        check_eq("chg_cnt",    32'(chg_cnt),    32'(m_cnt));
        check_eq("seg_idx_lo", 32'(seg_idx_lo), 32'(m_seg_il));
        check_eq("seg_idx_hi", 32'(seg_idx_hi), 32'(m_seg_ih));
        check_eq("seg_cnt_lo", 32'(seg_cnt_lo), 32'(m_seg_cl));
        check_eq("seg_cnt_hi", 32'(seg_cnt_hi), 32'(m_seg_ch));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_idx"},   32'(idx),        32'd0);
        check_eq({tag, "_valid"}, 32'(valid),      32'd0);
        check_eq({tag, "_cnt"},   32'(chg_cnt),    32'd0);
        check_eq({tag, "_sil"},   32'(seg_idx_lo), 32'hFF);
        check_eq({tag, "_sih"},   32'(seg_idx_hi), 32'hFF);
        check_eq({tag, "_scl"},   32'(seg_cnt_lo), 32'hFF);
        check_eq({tag, "_sch"},   32'(seg_cnt_hi), 32'hFF);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_state("rst0");
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check_eq("cnt_digits_lo_00", 32'(seg_cnt_lo), 32'hC0);
        check_eq("cnt_digits_hi_00", 32'(seg_cnt_hi), 32'hC0);

        // Highest-first then lowest-first on 0010_0100
        req = 8'b0010_0100;
        tick(7);
        check_eq("pre_edge7_valid", 32'(valid), 32'd0);
        tick(1);
        check_eq("e7_idx", 32'(idx), 32'd5);
        check_eq("e7_valid", 32'(valid), 32'd1);
        check_eq("e7_cnt", 32'(chg_cnt), 32'd0);
        tick(1);
        check_eq("e8_cnt", 32'(chg_cnt), 32'd1);
        check_eq("seg_idx_lo_5dp", 32'(seg_idx_lo), 32'h12);
        lowfirst = 1'b1;
        tick(1);
        check_eq("low_idx", 32'(idx), 32'd2);
        tick(1);
        check_eq("low_cnt", 32'(chg_cnt), 32'd2);
        lowfirst = 1'b0;
        tick(2);
        check_eq("high_cnt", 32'(chg_cnt), 32'd3);

        // Glitch on req[7] shorter than the debounce window
        req = 8'b1010_0100;
        tick(3);
        req = 8'b0010_0100;
        tick(10);
        check_eq("glitch_idx", 32'(idx), 32'd5);
        check_eq("glitch_cnt", 32'(chg_cnt), 32'd3);

        // Hold freezes outputs while debounce keeps running
        hold = 1'b1;
        req  = 8'h80;
        tick(10);
        check_eq("hold_idx", 32'(idx), 32'd5);
        check_eq("hold_cnt", 32'(chg_cnt), 32'd3);
        hold = 1'b0;
        tick(1);
        check_eq("release_idx", 32'(idx), 32'd7);
        tick(1);
        check_eq("release_cnt", 32'(chg_cnt), 32'd4);
        tick(3);
        check_eq("release_cnt_once", 32'(chg_cnt), 32'd4);

        // Reset mid-debounce
        req = 8'h55;
        tick(3);
        rst = 1'b1;
        #1 check_reset_state("rst_mid");
        req = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(10);
        check_eq("post_rst_valid", 32'(valid), 32'd0);
        check_eq("post_rst_cnt", 32'(chg_cnt), 32'd0);

        // 256 counted changes wrap the counter
        for (int i = 0; i < 256; i++) begin
            req = (i % 2 == 0) ? 8'h01 : 8'h02;
            tick(8);
            if (i == 127) check_eq("wrap_mid_cnt", 32'(chg_cnt), 32'd127);
        end
        tick(4);
        check_eq("wrap_cnt", 32'(chg_cnt), 32'd0);
        tick(1);
        check_eq("wrap_seg_lo", 32'(seg_cnt_lo), 32'hC0);
        check_eq("wrap_seg_hi", 32'(seg_cnt_hi), 32'hC0);

        // Disabled encoder blanks index digits, counter still shown
        en  = 1'b0;
        req = 8'hFF;
        tick(10);
        check_eq("dis_valid", 32'(valid), 32'd0);
        check_eq("dis_idx", 32'(idx), 32'd0);
        check_eq("dis_seg_lo", 32'(seg_idx_lo), 32'hFF);
        check_eq("dis_seg_hi", 32'(seg_idx_hi), 32'hFF);
        check_eq("dis_cnt", 32'(chg_cnt), 32'd1);
        check_eq("dis_seg_cnt", 32'(seg_cnt_lo), 32'hF9);

        // Random phase: glitches, holds, direction and enable changes
        for (int k = 0; k < 150; k++) begin
            req      = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            lowfirst = 1'($urandom_range(0, 1));
            hold     = ($urandom_range(0, 5) == 0);
            en       = ($urandom_range(0, 7) != 0);
            tick($urandom_range(1, 9));
        end
        hold = 1'b0;
        en   = 1'b1;
        tick(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_enc_disp.md
# prio_enc_disp

Parametrised, registered priority encoder for the board switch/LED/seven-segment path. It generalises the 8-to-3 encoder with enable and pilot LED to WIDTH request lines, selectable priority direction, input synchronisation and debounce, a hold mode and a change-event counter. Index and counter are shown on four active-low seven-segment digits. It sits under `top`, fed from `sw`, driving `ledr` and `seg0`–`seg3`.

## Interface
- `WIDTH`, 16: number of request lines; power of two, 2–256.
- `DEB_CYCLES`, 1000: consecutive stable cycles required before a request vector is accepted; ≥1.
- `IW`, derived = $clog2(WIDTH): index width; not overridable.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in WIDTH: raw request lines (switches), asynchronous to `clk`.
- `en` in 1: encoder enable.
- `lowfirst` in 1: 0 = highest index wins; 1 = lowest index wins.
- `hold` in 1: freeze outputs and counter.
- `idx` out IW: encoded winning index.
- `valid` out 1: pilot; at least one accepted request while enabled.
- `chg_cnt` out 8: count of changes of (`valid`,`idx`).
- `seg_idx_lo`, `seg_idx_hi`, `seg_cnt_lo`, `seg_cnt_hi` out 8 each: active-low digits, bit7 = dp, bits6:0 = g..a.

## Operation
- `req` passes a 2-FF synchroniser, giving `req_s`.
- Debounce: a candidate register and a stability counter. When `req_s` ≠ candidate, the candidate loads `req_s` and the counter clears. Otherwise the counter increments. When it reaches DEB_CYCLES−1, `req_db` loads the candidate and the counter saturates until the next difference.
- Encoder is registered each cycle unless `hold`=1:
  - `en`=1: `valid` = |`req_db`. `idx` = highest set bit, or lowest set bit when `lowfirst`=1. `idx`=0 when no bit is set.
  - `en`=0: `valid`=0, `idx`=0.
- `chg_cnt` increments by 1 in the cycle after the registered (`valid`,`idx`) pair differs from its previous value, `hold`=0. It wraps 255→0.
- `lowfirst` toggling with `req_db` unchanged counts as a change only if `idx` changes.
- `hold`=1: `idx`, `valid`, `chg_cnt` frozen. Debounce keeps running. On release the encoder samples the current `req_db`; a resulting difference counts once.
- Segment digits:
  - Hex font 0–F.
  - `seg_idx_hi` shows `idx[7:4]` (zero-extended); it is blank (8'hFF) when IW ≤ 4.
  - The dp of `seg_idx_lo` is lit (0) when `valid`=1.
  - When `en`=0, the index digits are blank and the counter digits still show `chg_cnt`.
- Reset values:
  - `idx`=0, `valid`=0, `chg_cnt`=0.
  - Synchroniser, candidate, `req_db` and counter all 0.
  - All seg outputs 8'hFF.

## Timing
- Input change sampled at edge 0 reaches `req_s` after edge 2.
- `req_db` updates at edge 2+DEB_CYCLES if `req_s` is stable.
- `idx`/`valid` update at edge 3+DEB_CYCLES.
- `chg_cnt` updates at edge 4+DEB_CYCLES.
- Segments are registered: index digits one edge after `idx`, counter digits one edge after `chg_cnt`.
- `en` and `lowfirst` are used directly (static board controls, not synchronised). Their effect appears at the next edge on `idx`/`valid`.
- A glitch shorter than DEB_CYCLES restarts the counter and never reaches `req_db`.
- `rst` asserted mid-debounce or mid-hold clears everything immediately. After deassertion, an all-zero `req` gives `valid`=0 and no count.

## Structure
- Shared package `prio_enc_pkg`:
  - `SEG_BLANK` (8'hFF).
  - 16-entry hex font constant.
  - Function `hex2seg(input [3:0])` returning 7-bit g..a.
- Sub-module `req_debounce` (WIDTH, DEB_CYCLES): synchroniser, candidate, counter, `req_db` output.
- Encoder, change counter and seg registers live in `prio_enc_disp`.

## Test plan
All scenarios use WIDTH=8, DEB_CYCLES=4.
- Reset, `en`=1, `req`=8'h00 → `valid`=0, `idx`=0, `chg_cnt`=0, all segs 8'hFF until the first post-reset edge; then the counter digits read "00".
- `req`=8'b0010_0100, `lowfirst`=0 → `idx`=5, `valid`=1 at edge 7, `chg_cnt`=1 at edge 8, `seg_idx_lo`=hex "5" with dp lit. Set `lowfirst`=1 → `idx`=2, `chg_cnt`=2.
- 3-cycle pulse on `req[7]` with other bits stable → `idx` unchanged, `chg_cnt` unchanged.
- `hold`=1, then `req`=8'h80 held 10 cycles → outputs frozen. Release `hold` → `idx`=7 next edge, `chg_cnt`+1 exactly once.
- Drive 256 alternating `req` changes (8'h01/8'h02) → `chg_cnt` wraps to 0 and `seg_cnt_*` read "00".
- `en`=0 with `req`=8'hFF → `valid`=0, `idx`=0, index digits 8'hFF. Assert `rst` mid-debounce → all state cleared immediately.
